// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int DMEM_LATENCY     = 4;
  localparam int DMEM_DEPTH_WORDS = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// EX/MEM request fields and the responder's load data / stall / ack outputs.
interface dmem_responder_if;
  logic        MemRd_i;
  logic        MemWr_i;
  logic [31:0] Addr_i;
  logic [31:0] WrData_i;
  logic [31:0] RdData_o;
  logic        Stall_o;
  logic        Ack_o;

  modport master (
    output MemRd_i, MemWr_i, Addr_i, WrData_i,
    input  RdData_o, Stall_o, Ack_o
  );

  modport slave (
    input  MemRd_i, MemWr_i, Addr_i, WrData_i,
    output RdData_o, Stall_o, Ack_o
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read so the
// responder owns the registered, resettable load-data output.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (we) mem_q[idx] <= wdata;

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage; stalls the pipeline
// from the accept cycle until the access completes, then pulses Ack for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int LATENCY     = DMEM_LATENCY
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int IW = clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_BUSY = 2'(ST_BUSY);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [31:0]   arr_rdata;
  logic          req, accept, access;

  assign req    = bus.MemRd_i | bus.MemWr_i;
  assign accept = (state_q == S_IDLE) & req;
  assign access = (state_q == S_BUSY) & (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_BUSY;
        cnt_d   = CW'(LATENCY - 1);
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access && !wr_q) rdata_q <= arr_rdata;
    end
  end

  // Request fields are only consumed after an accept, so they need no reset.
  // Store wins on a dual strobe because wr_q simply follows MemWr_i.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wr_q    <= bus.MemWr_i;
      idx_q   <= bus.Addr_i[2 +: IW];
      wdata_q <= bus.WrData_i;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_array (
    .clk   (clk_i),
    .we    (access & wr_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.RdData_o = rdata_q;
  assign bus.Ack_o    = (state_q == S_DONE);
  assign bus.Stall_o  = rst_i & (accept | (state_q == S_BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder, plus a LATENCY=1 instance
// exercising back-to-back loads.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT    = 4;
  localparam int DEPTH  = 256;
  localparam int LAT1   = 1;
  localparam int DEPTH1 = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i (clk), .rst_i (rst_n), .bus (bus.slave)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(LAT1)) dut1 (
    .clk_i (clk), .rst_i (rst_n), .bus (bus1.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd = '0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every Ack pops one expected RdData and checks the stall length.
  always @(negedge clk) begin
    if (!rst_n) stall_cnt = 0;
    else begin
      if (bus.Stall_o) stall_cnt++;
      if (bus.Ack_o) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else begin
          exp_v = exp_q.pop_front();
          chk("rddata", bus.RdData_o, exp_v);
          chk("stall_len", stall_cnt, LAT + 1);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int idx;
    int n;
    idx = int'((a >> 2) & (DEPTH - 1));
    @(posedge clk); #1;
    bus.MemRd_i = rd; bus.MemWr_i = wr; bus.Addr_i = a; bus.WrData_i = d;
    if (wr) ref_mem[idx] = d;
    else    last_rd = ref_mem[idx];
    exp_q.push_back(last_rd);
    for (n = 0; n < LAT + 10; n++) begin
      @(posedge clk); #1;
      if (bus.Ack_o) break;
    end
    if (n == LAT + 10) chk("ack_timeout", 32'd0, 32'd1);
    else               chk("ack_latency", n, LAT);
    bus.MemRd_i = 1'b0; bus.MemWr_i = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      chk("idle_stall", bus.Stall_o, 1'b0);
      chk("idle_ack", bus.Ack_o, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] w0, w1, a, d;
    int r, k, nst;
    int ack_t [2];
    int st_n  [2];
    logic [31:0] rd_v [2];

    bus.MemRd_i = 0; bus.MemWr_i = 0; bus.Addr_i = 0; bus.WrData_i = 0;
    bus1.MemRd_i = 0; bus1.MemWr_i = 0; bus1.Addr_i = 0; bus1.WrData_i = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_stall", bus.Stall_o, 1'b0);
    chk("rst_ack", bus.Ack_o, 1'b0);
    chk("rst_rddata", bus.RdData_o, 32'h0);

    for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    idle(1);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 1'b1, 32'h400, 32'h12345678);
    issue(1'b1, 1'b0, 32'h000, 32'h0);
    issue(1'b1, 1'b0, 32'h003, 32'h0);
    issue(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    idle(2);

    // Store aborted by reset mid-BUSY must not reach the array.
    @(posedge clk); #1;
    bus.MemWr_i = 1'b1; bus.Addr_i = 32'h30; bus.WrData_i = 32'h11111111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("rst_mid_stall", bus.Stall_o, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_stall", bus.Stall_o, 1'b0);
    chk("rst_hold_ack", bus.Ack_o, 1'b0);
    bus.MemWr_i = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", bus.Stall_o, 1'b0);
    chk("post_rst_rddata", bus.RdData_o, 32'h0);
    last_rd = '0;
    issue(1'b1, 1'b0, 32'h30, 32'h0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 3);
      a = $urandom;
      d = $urandom;
      issue(r != 1, r == 1 || r == 2, a, d);
      idle($urandom_range(0, 2));
    end

    // LATENCY=1 instance: seed two words, then back-to-back loads.
    w0 = $urandom; w1 = $urandom;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      bus1.MemWr_i = 1'b1; bus1.Addr_i = 32'(j * 4); bus1.WrData_i = (j == 0) ? w0 : w1;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        if (bus1.Ack_o) break;
      end
      bus1.MemWr_i = 1'b0;
    end
    @(posedge clk); #1;
    bus1.MemRd_i = 1'b1; bus1.Addr_i = 32'h0;
    k = 0; nst = 0;
    ack_t[0] = -1; ack_t[1] = -1; st_n[0] = 0; st_n[1] = 0; rd_v[0] = '0; rd_v[1] = '0;
    for (int t = 0; t < 10; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      if (bus1.Stall_o) nst++;
      if (bus1.Ack_o && k < 2) begin
        ack_t[k] = t; st_n[k] = nst; rd_v[k] = bus1.RdData_o;
        nst = 0;
        if (k == 0) bus1.Addr_i = 32'h4;
        else        bus1.MemRd_i = 1'b0;
        k++;
      end
    end
    bus1.MemRd_i = 1'b0;
    chk("l1_ack_count", k, 2);
    chk("l1_stall0", st_n[0], 2);
    chk("l1_stall1", st_n[1], 2);
    chk("l1_ack_gap", ack_t[1] - ack_t[0], 3);
    chk("l1_rd0", rd_v[0], w0);
    chk("l1_rd1", rd_v[1], w1);

    idle(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the MEM stage of the 5-stage MIPS pipeline. It consumes the memory-request fields latched by the EX/MEM pipeline register (read/write strobes, ALU-computed address, store data), models a fixed access latency, and freezes the pipeline through a stall signal until the access completes. Load data is returned registered, for capture by the MEM/WB register on the cycle the stall drops.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 2.
- LATENCY, 4: access latency in cycles; at least 1.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- MemRd_i  in  1  load request from EX/MEM.
- MemWr_i  in  1  store request from EX/MEM.
- Addr_i  in  32  byte address (EX/MEM ALU result).
- WrData_i  in  32  store data (EX/MEM MemData).
- RdData_o  out  32  load data; registered.
- Stall_o  out  1  pipeline freeze; PC, IF/ID, ID/EX, EX/MEM hold while high.
- Ack_o  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, BUSY, DONE.
- Word index is Addr_i[2 +: log2(DEPTH_WORDS)]. Bits [1:0] and the bits above the index are ignored, so addresses wrap modulo the array size.
- IDLE:
  - If MemRd_i or MemWr_i is high, accept the request: latch op, index and WrData_i; load the counter with LATENCY-1; go to BUSY.
  - If both strobes are high, the store wins.
- BUSY:
  - While the counter is nonzero, decrement it.
  - When the counter is 0, perform the access and go to DONE.
  - Store: array[idx] <= data.
  - Load: RdData_o <= array[idx].
- DONE: Ack_o is 1 and Stall_o is 0. Go to IDLE unconditionally.
- Stall_o = (IDLE & (MemRd_i | MemWr_i)) | BUSY. It is combinational, so the stall covers the accept cycle itself.
- Inputs are ignored in BUSY and DONE.
- A new request in the cycle after DONE is a new instruction, because EX/MEM advanced at the DONE edge.
- RdData_o holds its value until the next load completes. Stores do not change it.
- Reset:
  - Asynchronous; drives the state to IDLE, the counter to 0, RdData_o to 0 and Ack_o to 0.
  - While rst_i is low, Stall_o is forced to 0.
  - A pending store is aborted and not written.
  - Array contents are not cleared and survive reset.

## Timing
- A request present in cycle 0 (IDLE) gives:
  - BUSY in cycles 1..LATENCY;
  - DONE in cycle LATENCY+1;
  - Stall_o high in cycles 0..LATENCY, i.e. LATENCY+1 cycles.
- The access happens at the rising edge ending cycle LATENCY. RdData_o is valid throughout DONE and beyond.
- Back-to-back requests: DONE → IDLE (new request accepted, stall high immediately). Throughput is one access per LATENCY+2 cycles.
- Cycles with no request: Stall_o = 0, zero overhead.
- Store-then-load to the same address: the load returns the new data, since the store commits before the load is accepted.
- Reset asserted mid-BUSY: the next cycle after release is IDLE with Stall_o = 0 unless a request is present.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the default LATENCY and DEPTH_WORDS constants;
  - the index-width function clog2.
- Sub-module dmem_array: synchronous single-port word array.
  - Ports: clk, we, idx, wdata, rdata.
  - No reset.
  - Instantiated once.
- The FSM and counter stay in the top level.

## Test plan
- Reset release, idle inputs (MemRd_i = MemWr_i = 0) → Stall_o = 0, Ack_o = 0, RdData_o = 0.
- LATENCY=4:
  - Store 0xDEADBEEF at Addr_i=0x10 in cycle 0 → Stall_o high for cycles 0–4, Ack_o high in cycle 5.
  - Then load from 0x10 → RdData_o = 0xDEADBEEF in its DONE cycle.
- Address wrap with DEPTH_WORDS=256:
  - Store 0x12345678 at 0x400, then load from 0x000 → 0x12345678.
  - Load from 0x003 → same word.
- MemRd_i and MemWr_i both high with WrData_i=0xA5A5A5A5 at 0x20 → treated as a store; a later load of 0x20 returns 0xA5A5A5A5, and RdData_o is unchanged by the dual request.
- Store 0x11111111 to 0x30 in progress, rst_i pulsed low in cycle 2 → Stall_o = 0 during reset.
  - After release, a load of 0x30 returns the prior contents, not 0x11111111.
- LATENCY=1, back-to-back loads of 0x0 and 0x4 → each stalls 2 cycles, Ack_o pulses 3 cycles apart, and RdData_o matches each word.
